// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the multi-approach traffic phase controller:
//   lamp codes driven onto the per-way light fields, the phase encodings
//   exposed on the phase output, and a helper that sizes the way index.
package traffic_pkg;

  // Lamp code for one approach, two bits per way on the lights bus.
  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } lamp_t;

  // Controller phase.
  typedef enum logic [1:0] {
    GREEN_PH   = 2'd0,
    YELLOW_PH  = 2'd1,
    ALL_RED_PH = 2'd2,
    FLASH_PH   = 2'd3
  } phase_t;

  // Width of a way index: at least one bit, even for two approaches.
  function automatic int way_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/traffic_rr_select.sv
// traffic_rr_select
//   Combinational round-robin selector. Starting just after cur_way and
//   wrapping around, returns the first way whose request bit is set.
//   Ports:
//     req      in   NUM_WAYS  effective request vector (bit 0 normally tied high)
//     cur_way  in   WAY_W     way that owns (or last owned) green
//     nxt_way  out  WAY_W     next way to serve
module traffic_rr_select #(
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = 1
) (
  input  logic [NUM_WAYS-1:0] req,
  input  logic [WAY_W-1:0]    cur_way,
  output logic [WAY_W-1:0]    nxt_way
);

  logic [WAY_W-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest requesting
  // way overwrites the others. The offset NUM_WAYS lands back on cur_way,
  // which covers the case where cur_way is the only requester.
  always_comb begin
    nxt_way = '0;
    idx     = '0;
    for (int k = NUM_WAYS; k >= 1; k--) begin
      idx = WAY_W'((int'(cur_way) + k) % NUM_WAYS);
      if (req[idx]) begin
        nxt_way = idx;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
//   Multi-approach traffic signal controller with round-robin service,
//   minimum/maximum green limits and a flashing-yellow maintenance mode.
//   All durations count ticks of an external time-base strobe.
//   Ports:
//     clk      in   1           clock, rising edge
//     reset_n  in   1           asynchronous active-low reset
//     tick     in   1           time-base strobe; timers advance only when high
//     demand   in   NUM_WAYS    vehicle sensors; bit 0 ignored (home always requests)
//     flash    in   1           maintenance-mode request (level)
//     lights   out  2*NUM_WAYS  lamp code per way, way i at [2i+1:2i]
//     cur_way  out  WAY_W       way owning, or last owning, green
//     phase    out  2           current phase encoding
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_WAYS     = 2,
  parameter int TIMER_W      = 8,
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 16,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2,
  localparam int WAY_W       = way_width(NUM_WAYS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic [NUM_WAYS-1:0]   demand,
  input  logic                  flash,
  output logic [2*NUM_WAYS-1:0] lights,
  output logic [WAY_W-1:0]      cur_way,
  output logic [1:0]            phase
);

  localparam int TMAX = (1 << TIMER_W) - 1;

  // Parameter legality, rejected at elaboration.
  if (NUM_WAYS < 2 || NUM_WAYS > 8) begin : g_bad_ways
    $error("traffic_phase_ctrl: NUM_WAYS must be in 2..8");
  end
  if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN) begin : g_bad_green
    $error("traffic_phase_ctrl: need 1 <= MIN_GREEN <= MAX_GREEN");
  end
  if (YELLOW_TIME < 1 || ALL_RED_TIME < 1) begin : g_bad_clear
    $error("traffic_phase_ctrl: YELLOW_TIME and ALL_RED_TIME must be >= 1");
  end
  if (MAX_GREEN > TMAX || YELLOW_TIME > TMAX || ALL_RED_TIME > TMAX) begin : g_bad_width
    $error("traffic_phase_ctrl: a duration does not fit in TIMER_W bits");
  end

  localparam logic [TIMER_W:0]   MIN_C   = (TIMER_W+1)'(MIN_GREEN);
  localparam logic [TIMER_W:0]   MAX_C   = (TIMER_W+1)'(MAX_GREEN);
  localparam logic [TIMER_W-1:0] Y_LAST  = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] AR_LAST = TIMER_W'(ALL_RED_TIME - 1);

  phase_t               phase_q, phase_d;
  logic [WAY_W-1:0]     way_q, way_d, rr_way;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 tog_q, tog_d;
  logic                 force_q, force_d;
  logic [NUM_WAYS-1:0]  req;
  logic [TIMER_W:0]     elapsed;
  logic                 side_req, min_met, max_met, green_done;

  // Home way always requests; bit 0 of demand is overridden here.
  assign req      = demand | NUM_WAYS'(1);
  assign side_req = |req[NUM_WAYS-1:1];

  // elapsed is the tick count as it will stand after this edge, so a
  // threshold of N ticks is met on the very edge that delivers tick N.
  assign elapsed = {1'b0, timer_q} + (TIMER_W+1)'(tick);
  assign min_met = (elapsed >= MIN_C);
  assign max_met = (elapsed >= MAX_C);

  // Home leaves green only for a waiting side road; a side road leaves when
  // its car is gone or its maximum is used up. flash overrides MIN_GREEN.
  assign green_done = flash ||
                      (min_met && ((way_q == '0) ? side_req
                                                 : (!req[way_q] || max_met)));

  traffic_rr_select #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_rr (
    .req     (req),
    .cur_way (way_q),
    .nxt_way (rr_way)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= ALL_RED_PH;
      way_q   <= '0;
      timer_q <= '0;
      tog_q   <= 1'b0;
      force_q <= 1'b1;
    end else begin
      phase_q <= phase_d;
      way_q   <= way_d;
      timer_q <= timer_d;
      tog_q   <= tog_d;
      force_q <= force_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    way_d   = way_q;
    timer_d = timer_q;
    tog_d   = tog_q;
    force_d = force_q;
    unique case (phase_q)
      GREEN_PH: begin
        if (green_done) begin
          phase_d = YELLOW_PH;
          timer_d = '0;
        end else begin
          // Saturate so a long home green cannot wrap the timer.
          timer_d = max_met ? MAX_C[TIMER_W-1:0] : elapsed[TIMER_W-1:0];
        end
      end
      YELLOW_PH: begin
        if (tick && timer_q == Y_LAST) begin
          phase_d = ALL_RED_PH;
          timer_d = '0;
        end else begin
          timer_d = elapsed[TIMER_W-1:0];
        end
      end
      ALL_RED_PH: begin
        if (tick && timer_q == AR_LAST) begin
          timer_d = '0;
          if (flash) begin
            phase_d = FLASH_PH;
            tog_d   = 1'b0;
          end else begin
            // After reset or maintenance, service restarts at the home way.
            phase_d = GREEN_PH;
            way_d   = force_q ? '0 : rr_way;
            force_d = 1'b0;
          end
        end else begin
          timer_d = elapsed[TIMER_W-1:0];
        end
      end
      FLASH_PH: begin
        if (!flash) begin
          phase_d = ALL_RED_PH;
          timer_d = '0;
          tog_d   = 1'b0;
          force_d = 1'b1;
        end else if (tick) begin
          tog_d = ~tog_q;
        end
      end
      default: begin
        phase_d = ALL_RED_PH;
        timer_d = '0;
      end
    endcase
  end

  // Lamp decode uses registers only, so outputs never see input glitches.
  always_comb begin
    lights = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (phase_q == FLASH_PH) begin
        lights[2*i +: 2] = tog_q ? YELLOW : RED;
      end else if (WAY_W'(i) == way_q) begin
        if (phase_q == GREEN_PH) begin
          lights[2*i +: 2] = GREEN;
        end else if (phase_q == YELLOW_PH) begin
          lights[2*i +: 2] = YELLOW;
        end
      end
    end
  end

  assign phase   = phase_q;
  assign cur_way = way_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl
//   Self-checking bench for traffic_phase_ctrl with NUM_WAYS=3, MIN=4,
//   MAX=8, YELLOW=3, ALL_RED=2. A behavioural model tracks ticks spent in
//   each phase and which way is served; directed tables pin down the
//   exact phase sequences; a random run exercises mixed tick/demand/flash.
module tb_traffic_phase_ctrl;

  localparam int NW   = 3;
  localparam int MING = 4;
  localparam int MAXG = 8;
  localparam int YT   = 3;
  localparam int ART  = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic [2:0] demand;
  logic       flash;
  logic [5:0] lights;
  logic [1:0] cur_way;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: phase number, served way, ticks spent in the
  // phase, flash toggle, and "restart at home" flag.
  int m_phase, m_way, m_el, m_tog, m_force;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .NUM_WAYS     (NW),
    .TIMER_W      (8),
    .MIN_GREEN    (MING),
    .MAX_GREEN    (MAXG),
    .YELLOW_TIME  (YT),
    .ALL_RED_TIME (ART)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .demand  (demand),
    .flash   (flash),
    .lights  (lights),
    .cur_way (cur_way),
    .phase   (phase)
  );

  task automatic model_reset();
    m_phase = 2;
    m_way   = 0;
    m_el    = 0;
    m_tog   = 0;
    m_force = 1;
  endtask

  function automatic int rr_next(input int w, input logic [2:0] d);
    for (int k = 1; k <= NW; k++) begin
      int j;
      j = (w + k) % NW;
      if (j == 0 || d[j] == 1'b1) return j;
    end
    return 0;
  endfunction

  task automatic model_step(input logic t, input logic [2:0] d, input logic f);
    int el;
    bit go;
    el = m_el + (t ? 1 : 0);
    case (m_phase)
      0: begin
        if (m_way == 0) go = d[1] || d[2];
        else            go = (d[m_way] == 1'b0) || (el >= MAXG);
        go = f || ((el >= MING) && go);
        if (go) begin
          m_phase = 1;
          m_el    = 0;
        end else begin
          m_el = (el > MAXG) ? MAXG : el;
        end
      end
      1: begin
        if (el >= YT) begin
          m_phase = 2;
          m_el    = 0;
        end else m_el = el;
      end
      2: begin
        if (el >= ART) begin
          m_el = 0;
          if (f) begin
            m_phase = 3;
            m_tog   = 0;
          end else begin
            m_phase = 0;
            m_way   = m_force ? 0 : rr_next(m_way, d);
            m_force = 0;
          end
        end else m_el = el;
      end
      default: begin
        if (!f) begin
          m_phase = 2;
          m_el    = 0;
          m_tog   = 0;
          m_force = 1;
        end else if (t) begin
          m_tog = 1 - m_tog;
        end
      end
    endcase
  endtask

  function automatic logic [5:0] exp_lights();
    logic [5:0] v;
    v = '0;
    for (int i = 0; i < NW; i++) begin
      if (m_phase == 3)                     v[2*i +: 2] = (m_tog != 0) ? 2'd1 : 2'd0;
      else if (i == m_way && m_phase == 0)  v[2*i +: 2] = 2'd2;
      else if (i == m_way && m_phase == 1)  v[2*i +: 2] = 2'd1;
    end
    return v;
  endfunction

  function automatic int nonred(input logic [5:0] l);
    int n;
    n = 0;
    for (int i = 0; i < NW; i++) if (l[2*i +: 2] != 2'd0) n++;
    return n;
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, and
  // leave time 1 ns past the edge for sampling.
  task automatic drive(input logic t, input logic [2:0] d, input logic f);
    tick   = t;
    demand = d;
    flash  = f;
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_step(t, d, f);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] dl;
    logic [1:0] dp;
    reset_n = 1'b0;
    model_reset();
    drive(1'b1, 3'b000, 1'b0);
    drive(1'b1, 3'b000, 1'b0);
    checks++;
    if (lights !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_lights got=%h want=%h", lights, 6'b0);
    end
    checks++;
    if (phase !== 2'd2) begin
      errors++;
      $display("[TB] FAIL reset_phase got=%0d want=2", phase);
    end
    checks++;
    if (cur_way !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_way got=%0d want=0", cur_way);
    end
    reset_n = 1'b1;
    // Sample 0 is the second all-red cycle; from sample 1 on home is green.
    for (int i = 0; i < 101; i++) begin
      drive(1'b1, 3'b000, 1'b0);
      dl = (i == 0) ? 6'b000000 : 6'b000010;
      dp = (i == 0) ? 2'd2 : 2'd0;
      checks++;
      if (lights !== dl || phase !== dp) begin
        errors++;
        $display("[TB] FAIL idle_seq i=%0d got lights=%h phase=%0d want lights=%h phase=%0d",
                 i, lights, phase, dl, dp);
      end
      checks++;
      if (lights !== exp_lights() || phase !== 2'(m_phase) || cur_way !== 2'(m_way)) begin
        errors++;
        $display("[TB] FAIL idle_model i=%0d got %h/%0d/%0d want %h/%0d/%0d",
                 i, lights, phase, cur_way, exp_lights(), m_phase, m_way);
      end
    end
  endtask

  task automatic test_side_demand();
    int ph [7] = '{0, 1, 2, 0, 1, 2, 0};
    int wy [7] = '{0, 0, 0, 2, 2, 2, 0};
    int ln [7] = '{4, 3, 2, 8, 3, 2, 1};
    int n;
    reset_n = 1'b0;
    drive(1'b1, 3'b000, 1'b0);
    reset_n = 1'b1;
    drive(1'b1, 3'b000, 1'b0);
    n = 0;
    for (int s = 0; s < 7; s++) begin
      for (int k = 0; k < ln[s]; k++) begin
        drive(1'b1, (n == 0) ? 3'b000 : 3'b100, 1'b0);
        n++;
        checks++;
        if (phase !== 2'(ph[s]) || cur_way !== 2'(wy[s])) begin
          errors++;
          $display("[TB] FAIL side_seq seg=%0d k=%0d got phase=%0d way=%0d want phase=%0d way=%0d",
                   s, k, phase, cur_way, ph[s], wy[s]);
        end
        checks++;
        if (lights !== exp_lights() || phase !== 2'(m_phase) || cur_way !== 2'(m_way)) begin
          errors++;
          $display("[TB] FAIL side_model n=%0d got %h/%0d/%0d want %h/%0d/%0d",
                   n, lights, phase, cur_way, exp_lights(), m_phase, m_way);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int ph [10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
    int wy [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
    int ln [10] = '{4, 3, 2, 8, 3, 2, 8, 3, 2, 1};
    int n;
    reset_n = 1'b0;
    drive(1'b1, 3'b000, 1'b0);
    reset_n = 1'b1;
    drive(1'b1, 3'b000, 1'b0);
    n = 0;
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < ln[s]; k++) begin
        drive(1'b1, (n == 0) ? 3'b000 : 3'b110, 1'b0);
        n++;
        checks++;
        if (phase !== 2'(ph[s]) || cur_way !== 2'(wy[s])) begin
          errors++;
          $display("[TB] FAIL b2b_seq seg=%0d k=%0d got phase=%0d way=%0d want phase=%0d way=%0d",
                   s, k, phase, cur_way, ph[s], wy[s]);
        end
        checks++;
        if (nonred(lights) > 1) begin
          errors++;
          $display("[TB] FAIL b2b_conflict n=%0d lights=%h nonred=%0d want<=1", n, lights, nonred(lights));
        end
        checks++;
        if (lights !== exp_lights() || phase !== 2'(m_phase) || cur_way !== 2'(m_way)) begin
          errors++;
          $display("[TB] FAIL b2b_model n=%0d got %h/%0d/%0d want %h/%0d/%0d",
                   n, lights, phase, cur_way, exp_lights(), m_phase, m_way);
        end
      end
    end
  endtask

  task automatic test_flash();
    logic [5:0] dl;
    logic [1:0] dp;
    reset_n = 1'b0;
    drive(1'b1, 3'b000, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b1, 3'b000, 1'b0);
    // 3 yellow, 2 all-red, 10 flashing (starting RED), then flash released:
    // 2 all-red and home green again.
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 3'b000, (i < 15) ? 1'b1 : 1'b0);
      if (i < 3)       begin dl = 6'b000001; dp = 2'd1; end
      else if (i < 5)  begin dl = 6'b000000; dp = 2'd2; end
      else if (i < 15) begin dl = ((i - 5) % 2 == 1) ? 6'b010101 : 6'b000000; dp = 2'd3; end
      else if (i < 17) begin dl = 6'b000000; dp = 2'd2; end
      else             begin dl = 6'b000010; dp = 2'd0; end
      checks++;
      if (lights !== dl || phase !== dp) begin
        errors++;
        $display("[TB] FAIL flash_seq i=%0d got lights=%h phase=%0d want lights=%h phase=%0d",
                 i, lights, phase, dl, dp);
      end
      checks++;
      if (lights !== exp_lights() || phase !== 2'(m_phase) || cur_way !== 2'(m_way)) begin
        errors++;
        $display("[TB] FAIL flash_model i=%0d got %h/%0d/%0d want %h/%0d/%0d",
                 i, lights, phase, cur_way, exp_lights(), m_phase, m_way);
      end
    end
  endtask

  task automatic test_slow_tick_reset();
    int cyc;
    int green0;
    int yel;
    cyc    = 0;
    green0 = 0;
    yel    = 0;
    reset_n = 1'b0;
    drive(1'b1, 3'b000, 1'b0);
    reset_n = 1'b1;
    // Run until six samples into yellow; bounded in case the DUT never leaves green.
    for (int i = 0; i < 300 && yel < 6; i++) begin
      drive((cyc % 4) == 0, 3'b010, 1'b0);
      cyc++;
      if (phase === 2'd0 && cur_way === 2'd0) green0++;
      if (m_phase == 1) yel++;
      checks++;
      if (lights !== exp_lights() || phase !== 2'(m_phase) || cur_way !== 2'(m_way)) begin
        errors++;
        $display("[TB] FAIL slow_model i=%0d got %h/%0d/%0d want %h/%0d/%0d",
                 i, lights, phase, cur_way, exp_lights(), m_phase, m_way);
      end
    end
    checks++;
    if (green0 != 4 * MING || yel != 6) begin
      errors++;
      $display("[TB] FAIL slow_green got green=%0d yellow_seen=%0d want green=%0d yellow_seen=6",
               green0, yel, 4 * MING);
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (lights !== 6'b0 || phase !== 2'd2 || cur_way !== 2'd0) begin
      errors++;
      $display("[TB] FAIL async_reset got %h/%0d/%0d want 00/2/0", lights, phase, cur_way);
    end
    drive(1'b1, 3'b000, 1'b0);
    drive(1'b1, 3'b000, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive((cyc % 4) == 0, 3'b000, 1'b0);
      cyc++;
      checks++;
      if (lights !== exp_lights() || phase !== 2'(m_phase) || cur_way !== 2'(m_way)) begin
        errors++;
        $display("[TB] FAIL slow_restart i=%0d got %h/%0d/%0d want %h/%0d/%0d",
                 i, lights, phase, cur_way, exp_lights(), m_phase, m_way);
      end
    end
    checks++;
    if (lights !== 6'b000010 || phase !== 2'd0) begin
      errors++;
      $display("[TB] FAIL slow_home got lights=%h phase=%0d want 02/0", lights, phase);
    end
  endtask

  task automatic test_random();
    logic [2:0] d;
    logic       f;
    logic       t;
    d = 3'b000;
    f = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < NW; b++) if ($urandom_range(0, 7) == 0) d[b] = ~d[b];
      if ($urandom_range(0, 149) == 0) f = ~f;
      t = ($urandom_range(0, 2) != 0);
      drive(t, d, f);
      checks++;
      if (lights !== exp_lights() || phase !== 2'(m_phase) || cur_way !== 2'(m_way)) begin
        errors++;
        $display("[TB] FAIL rand_model i=%0d got %h/%0d/%0d want %h/%0d/%0d",
                 i, lights, phase, cur_way, exp_lights(), m_phase, m_way);
      end
      checks++;
      if (nonred(lights) > 1 && phase !== 2'd3) begin
        errors++;
        $display("[TB] FAIL rand_conflict i=%0d lights=%h nonred=%0d want<=1", i, lights, nonred(lights));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    tick    = 1'b0;
    demand  = 3'b000;
    flash   = 1'b0;
    model_reset();
    $display("[TB] start");
    test_reset();
    test_side_demand();
    test_back_to_back();
    test_flash();
    test_slow_tick_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
